// File: rtl/de_port_arbiter_if.sv
// One drawing-engine port: request/ack handshake, muxed address/control, both data paths.
// The master side drives the transfer fields; the slave side returns ack and read data.
interface de_port_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              req;
    logic              ack;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        nbyte;
    logic              rnw;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;

    modport master (
        output req, addr, nbyte, rnw, w_data,
        input  ack, r_data
    );

    modport slave (
        input  req, addr, nbyte, rnw, w_data,
        output ack, r_data
    );
endinterface

// File: rtl/de_port_arbiter.sv
// Purpose: two-master round-robin arbiter for the frame-store drawing-engine port.
// Latency: de_req follows a request from idle after 1 cycle; G0<->G1 handover has no dead cycle.
// Backpressure: masters hold req until their own ack; the owner yields after HOLD_MAX acks if the other waits.
module de_port_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 16
) (
    input  logic                clk,
    input  logic                rst,
    de_port_arbiter_if.slave    m0,
    de_port_arbiter_if.slave    m1,
    de_port_arbiter_if.master   de,
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [8:0] HOLD_LIM = 9'(HOLD_MAX);

    state_t     state;
    state_t     state_nxt;
    logic       last;       // 1: master 1 was granted most recently
    logic [7:0] hold_cnt;
    logic       hold_done;

    assign hold_done = (({1'b0, hold_cnt} + 9'd1) == HOLD_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                hold_cnt <= 8'd0;
                if (state_nxt != IDLE) begin
                    last <= (state_nxt == G1);
                end
            end else if (state != IDLE && de.ack && hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (m0.req && m1.req) begin
                    state_nxt = last ? G0 : G1;
                end else if (m0.req) begin
                    state_nxt = G0;
                end else if (m1.req) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                if (!m0.req) begin
                    state_nxt = m1.req ? G1 : IDLE;
                end else if (de.ack && m1.req && hold_done) begin
                    state_nxt = G1;
                end
            end
            G1: begin
                if (!m1.req) begin
                    state_nxt = m0.req ? G0 : IDLE;
                end else if (de.ack && m0.req && hold_done) begin
                    state_nxt = G0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output mux is purely a function of the registered owner, so reset idles it at once.
    always_comb begin
        de.req    = 1'b0;
        de.addr   = {ADDR_W{1'b0}};
        de.nbyte  = 4'hF;
        de.rnw    = 1'b1;
        de.w_data = {DATA_W{1'b0}};
        unique case (state)
            G0: begin
                de.req    = m0.req;
                de.addr   = m0.addr;
                de.nbyte  = m0.nbyte;
                de.rnw    = m0.rnw;
                de.w_data = m0.w_data;
            end
            G1: begin
                de.req    = m1.req;
                de.addr   = m1.addr;
                de.nbyte  = m1.nbyte;
                de.rnw    = m1.rnw;
                de.w_data = m1.w_data;
            end
            default: ;
        endcase
    end

    assign m0.ack    = de.ack & (state == G0);
    assign m1.ack    = de.ack & (state == G1);
    assign m0.r_data = de.r_data;
    assign m1.r_data = de.r_data;
    assign grant     = {state == G1, state == G0};

endmodule

// File: tb/tb_de_port_arbiter.sv
// Directed and randomized checks of de_port_arbiter against an owner/tenure reference model.
module tb_de_port_arbiter;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;

    always #5 clk = ~clk;

    de_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
    de_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
    de_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) de ();

    de_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(HM)) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0),
        .m1    (m1),
        .de    (de),
        .grant (grant)
    );

    int errors = 0;
    int checks = 0;

    // Reference: owner 0 = none, 1 = master 0, 2 = master 1; served = acks in this tenure.
    int owner;
    int last_g;
    int served;

    logic ack0_s, ack1_s;

    task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task model_reset();
        owner  = 0;
        last_g = 2;
        served = 0;
    endtask

    task check_outputs();
        logic [1:0]    eg;
        logic          ereq;
        logic [AW-1:0] eaddr;
        logic [3:0]    enb;
        logic          ernw;
        logic [DW-1:0] ewd;
        eg = 2'b00; ereq = 1'b0; eaddr = '0; enb = 4'hF; ernw = 1'b1; ewd = '0;
        if (owner == 1) begin
            eg = 2'b01; ereq = m0.req; eaddr = m0.addr; enb = m0.nbyte; ernw = m0.rnw; ewd = m0.w_data;
        end else if (owner == 2) begin
            eg = 2'b10; ereq = m1.req; eaddr = m1.addr; enb = m1.nbyte; ernw = m1.rnw; ewd = m1.w_data;
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("de_req", 64'(de.req), 64'(ereq));
        chk("de_addr", 64'(de.addr), 64'(eaddr));
        chk("de_nbyte", 64'(de.nbyte), 64'(enb));
        chk("de_rnw", 64'(de.rnw), 64'(ernw));
        chk("de_w_data", 64'(de.w_data), 64'(ewd));
        chk("m0_ack", 64'(m0.ack), 64'(de.ack && owner == 1));
        chk("m1_ack", 64'(m1.ack), 64'(de.ack && owner == 2));
        chk("m0_r_data", 64'(m0.r_data), 64'(de.r_data));
        chk("m1_r_data", 64'(m1.r_data), 64'(de.r_data));
        chk("hold_cnt", 64'(dut.hold_cnt), 64'(served));
    endtask

    task model_step();
        int  nxt;
        int  other;
        bit  me_req, ot_req;
        nxt = owner;
        if (owner == 0) begin
            if (m0.req && m1.req) nxt = (last_g == 2) ? 1 : 2;
            else if (m0.req)      nxt = 1;
            else if (m1.req)      nxt = 2;
        end else begin
            other  = 3 - owner;
            me_req = (owner == 1) ? m0.req : m1.req;
            ot_req = (owner == 1) ? m1.req : m0.req;
            if (!me_req)                                      nxt = ot_req ? other : 0;
            else if (de.ack && ot_req && served + 1 == HM)    nxt = other;
        end
        if (nxt != owner) begin
            served = 0;
            if (nxt != 0) last_g = nxt;
        end else if (owner != 0 && de.ack && served < 255) begin
            served++;
        end
        owner = nxt;
    endtask

    // Inputs are set just after a falling edge; outputs are sampled 1ns later.
    task cycle();
        #1;
        check_outputs();
        ack0_s = m0.ack;
        ack1_s = m1.ack;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task idle_inputs();
        m0.req = 0; m0.addr = '0; m0.nbyte = 4'hF; m0.rnw = 1; m0.w_data = '0;
        m1.req = 0; m1.addr = '0; m1.nbyte = 4'hF; m1.rnw = 1; m1.w_data = '0;
        de.ack = 0; de.r_data = '0;
    endtask

    task do_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_de_req", 64'(de.req), 64'd0);
        chk("rst_hold", 64'(dut.hold_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task pay0();
        m0.addr = AW'($urandom); m0.nbyte = 4'($urandom); m0.rnw = 1'($urandom); m0.w_data = $urandom;
    endtask

    task pay1();
        m1.addr = AW'($urandom); m1.nbyte = 4'($urandom); m1.rnw = 1'($urandom); m1.w_data = $urandom;
    endtask

    initial begin
        int n0, n1, k;
        logic saw_idle;
        ack0_s = 0; ack1_s = 0;
        do_reset();

        // Master 0 alone, ack every third cycle, five transfers.
        m0.req = 1; pay0();
        n0 = 0; n1 = 0; k = 0;
        while (n0 < 5 && k < 60) begin
            de.ack = (k % 3 == 2);
            de.r_data = $urandom;
            cycle();
            k++;
            if (ack1_s) n1++;
            if (ack0_s) begin
                n0++;
                if (n0 == 5) m0.req = 0; else pay0();
            end
        end
        de.ack = 0;
        chk("t1_m0_acks", 64'(n0), 64'd5);
        chk("t1_m1_acks", 64'(n1), 64'd0);
        cycle(); cycle();
        chk("t1_idle", 64'(grant), 64'd0);

        // Simultaneous requests from reset; master 0 hands over after one transfer.
        do_reset();
        m0.req = 1; m1.req = 1; pay0(); pay1();
        cycle();
        chk("t2_first", 64'(grant), 64'b01);
        cycle();
        de.ack = 1;
        cycle();
        de.ack = 0; m0.req = 0;
        saw_idle = (grant == 2'b00);
        cycle();
        saw_idle = saw_idle | (grant == 2'b00);
        chk("t2_to_m1", 64'(grant), 64'b10);
        chk("t2_no_idle", 64'(saw_idle), 64'd0);

        // Both saturating with ack every cycle: 4-transfer windows alternate.
        do_reset();
        m0.req = 1; m1.req = 1; pay0(); pay1(); de.ack = 1;
        cycle();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t3_window", 64'(grant), (((i / HM) % 2) == 0) ? 64'b01 : 64'b10);
            cycle();
            if (ack0_s) begin n0++; pay0(); end
            if (ack1_s) begin n1++; pay1(); end
        end
        chk("t3_m0_acks", 64'(n0), 64'd8);
        chk("t3_m1_acks", 64'(n1), 64'd8);

        // Master 1 write while master 0 is idle.
        do_reset();
        m1.req = 1; m1.rnw = 0; m1.nbyte = 4'b1011; m1.w_data = 32'hA5A5_0001; m1.addr = 18'h2_1234;
        cycle();
        #1;
        chk("t4_addr", 64'(de.addr), 64'h2_1234);
        chk("t4_nbyte", 64'(de.nbyte), 64'hB);
        chk("t4_wdata", 64'(de.w_data), 64'hA5A5_0001);
        chk("t4_rnw", 64'(de.rnw), 64'd0);
        cycle();
        de.ack = 1;
        cycle();
        de.ack = 0; m1.req = 0;
        cycle();
        #1;
        chk("t4_idle", 64'(grant), 64'd0);

        // Asynchronous reset mid-transfer while master 1 owns the port.
        do_reset();
        m1.req = 1; pay1();
        cycle(); cycle();
        #1;
        chk("t5_pre_req", 64'(de.req), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_req", 64'(de.req), 64'd0);
        chk("t5_async_grant", 64'(grant), 64'd0);
        chk("t5_async_ack", 64'(m1.ack), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        m0.req = 1; pay0();
        cycle(); cycle();
        #1;
        chk("t5_tie", 64'(grant), 64'b01);

        // Stray de_ack while idle.
        do_reset();
        de.ack = 1;
        for (int i = 0; i < 3; i++) cycle();
        #1;
        chk("t6_grant", 64'(grant), 64'd0);
        chk("t6_hold", 64'(dut.hold_cnt), 64'd0);
        chk("t6_ack", 64'({m0.ack, m1.ack}), 64'd0);

        // Long single-master burst saturates the tenure counter.
        do_reset();
        m0.req = 1; de.ack = 1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (ack0_s) pay0();
        end
        #1;
        chk("t7_sat", 64'(dut.hold_cnt), 64'd255);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m0.req) begin
                if (ack0_s) begin
                    if ($urandom_range(0, 2) == 0) m0.req = 0; else pay0();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                m0.req = 1; pay0();
            end
            if (m1.req) begin
                if (ack1_s) begin
                    if ($urandom_range(0, 2) == 0) m1.req = 0; else pay1();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                m1.req = 1; pay1();
            end
            de.ack = ($urandom_range(0, 2) == 0);
            de.r_data = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/de_port_arbiter.md
Name: de_port_arbiter

Overview:
- Two-master arbiter sharing the single frame-store drawing-engine port (de_req/de_ack/de_addr/de_nbyte/de_rnw/de_w_data/de_r_data).
- Master 0 is the dithering engine. Master 1 is a second drawing client, e.g. a host blitter or clear engine.
- The block switches ownership only at transfer boundaries and bounds consecutive grants so neither master starves.
- It sits between both masters and the frame-store controller.

Parameters:
- ADDR_W, 18, word address width of de_addr / mX_addr.
- DATA_W, 32, write/read data width.
- HOLD_MAX, 16, maximum consecutive transfers granted to one master while the other is requesting (legal range 1..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 transfer request; held high until acked.
- m0_ack  out  1  master 0 transfer-complete strobe.
- m0_addr  in  ADDR_W  master 0 word address.
- m0_nbyte  in  4  master 0 active-low byte enables.
- m0_rnw  in  1  master 0 read(1)/write(0).
- m0_w_data  in  DATA_W  master 0 write data.
- m0_r_data  out  DATA_W  read data to master 0.
- m1_req, m1_ack, m1_addr, m1_nbyte, m1_rnw, m1_w_data, m1_r_data  same as m0_*, for master 1.
- de_req  out  1  request to frame store.
- de_ack  in  1  frame-store completion strobe, one cycle per transfer.
- de_addr  out  ADDR_W  muxed address.
- de_nbyte  out  4  muxed byte enables.
- de_rnw  out  1  muxed direction.
- de_w_data  out  DATA_W  muxed write data.
- de_r_data  in  DATA_W  frame-store read data.
- grant  out  2  owner status: 00 idle, 01 master 0, 10 master 1.

Behaviour:
- Downstream protocol:
  - While de_req is high, de_addr/nbyte/rnw/w_data are stable.
  - A transfer completes in the cycle de_ack=1.
  - A requester may keep req high across back-to-back transfers, updating its address in the cycle after ack.
- State register, three states: IDLE, G0, G1. grant = {state==G1, state==G0}.
- Registered state: a transfer needs no extra handshake cycle.
  - de_req rises the cycle after mX_req is first sampled high in IDLE.
  - Minimum latency from mX_req to de_req is 1 cycle.
- Output mux is combinational from state:
  - G0: de_* = m0_*.
  - G1: de_* = m1_*.
  - IDLE: de_req=0, de_addr=0, de_nbyte=4'hF, de_rnw=1, de_w_data=0.
- Ack routing: mX_ack = de_ack & (state==GX), combinational. The non-owner never sees ack.
- Read data: de_r_data is broadcast to both m0_r_data and m1_r_data. Masters sample only on their own ack.
- Round-robin pointer `last`: records the last master granted. Reset value selects master 0 on the first tie.
- IDLE transitions:
  - Only m0_req → G0.
  - Only m1_req → G1.
  - Both requesting → the master that is not `last`.
- GX transitions, evaluated each cycle:
  - mX_req=0 and other req=1 → G(other).
  - mX_req=0 and other req=0 → IDLE.
  - de_ack=1, other req=1, and hold_cnt+1 == HOLD_MAX → G(other). The current master's pending req waits, with no ack.
  - Otherwise stay in GX.
- hold_cnt:
  - Width 8.
  - Increments on each de_ack while in GX.
  - Clears on any state change.
  - Never wraps: it saturates at 255 when the other master is idle.
- Direct handover G0↔G1 takes no dead cycle: de_req may stay high while the source switches.
- Simultaneous events:
  - de_ack together with mX_req falling is counted as a completed transfer, then the req=0 rule applies.
  - de_ack in IDLE is ignored; no mX_ack is produced.
- Async reset, including mid-transfer:
  - State → IDLE, hold_cnt=0, last=master 1 (so master 0 wins the first tie).
  - All outputs go to their IDLE values immediately: de_req=0, m0_ack=m1_ack=0, grant=00.

Test Plan:
- Only m0_req high; de_ack pulses every 3rd cycle; 5 transfers → de_req rises 1 cycle after m0_req, grant=01, 5 m0_ack pulses, m1_ack always 0, de_addr tracks m0_addr.
- m0_req and m1_req rise in the same cycle from reset → grant=01 first; m0 drops after 1 transfer → grant=10 in the next cycle, with no de_req low cycle in between.
- HOLD_MAX=4, both masters held high, ack every cycle → grant alternates 01 for 4 acks, 10 for 4 acks, repeating; each master gets exactly 4 acks per window.
- m1 write (rnw=0, nbyte=4'b1011, data 32'hA5A5_0001) while m0 is idle → de_* equal m1 values exactly; after the ack the arbiter returns to grant=00 when m1_req drops.
- Assert rst for 1 cycle while grant=10 with de_req high and no ack yet → de_req and grant go to 0 asynchronously; after release, m0 and m1 both requesting gives grant=01.
- de_ack pulsed while grant=00 → no m0_ack/m1_ack, state stays IDLE, hold_cnt stays 0.
